// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibits the bus, issues request-to-send, shifts a byte plus odd parity on device clocks, checks ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       ack_ok
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, STOP, ACK, WAIT_IDLE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [7:0]    shreg;
  logic          par;
  logic          clk_meta, clk_sync, clk_prev;
  logic          data_meta, data_sync;
  logic          fe, idle_lines, timed;

  // Synchronizers reset to the idle-high bus level so no false edge follows reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign fe         = clk_prev & ~clk_sync;
  assign idle_lines = clk_sync & data_sync;
  // Watchdog applies to every device-clocked phase; WAIT_IDLE completion takes priority.
  assign timed      = (state == SHIFT) || (state == STOP) || (state == ACK) ||
                      ((state == WAIT_IDLE) && !idle_lines);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      ack_ok      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            shreg      <= tx_data;
            par        <= ~^tx_data;
            state      <= INHIBIT;
            busy       <= 1'b1;
            ack_ok     <= 1'b0;
            ps2_clk_oe <= 1'b1;
            cnt        <= '0;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            state       <= RTS;
            ps2_data_oe <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RTS: begin
          state      <= SHIFT;
          ps2_clk_oe <= 1'b0;
          idx        <= '0;
          cnt        <= '0;
        end
        SHIFT: begin
          if (fe) begin
            if (idx == 4'd8) begin
              ps2_data_oe <= ~par;
              state       <= STOP;
            end else begin
              ps2_data_oe <= ~shreg[idx[2:0]];
              idx         <= idx + 4'd1;
            end
          end
        end
        STOP: begin
          if (fe) begin
            ps2_data_oe <= 1'b0;
            state       <= ACK;
          end
        end
        ACK: begin
          if (fe) begin
            if (!data_sync) begin
              ack_ok <= 1'b1;
              state  <= WAIT_IDLE;
            end else begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (idle_lines) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (timed) begin
        if (fe) begin
          cnt <= '0;
        end else if (cnt == TO_LAST) begin
          state       <= IDLE;
          error       <= 1'b1;
          busy        <= 1'b0;
          ack_ok      <= 1'b0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          cnt         <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  localparam int INH = 40;
  localparam int TO  = 3000;
  localparam int HP  = 50;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_pad, data_pad;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, error, ack_ok;

  assign clk_pad  = ~(ps2_clk_oe | dev_clk_low);
  assign data_pad = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .resetn(resetn), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(clk_pad), .ps2_data_in(data_pad),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .done(done), .error(error), .ack_ok(ack_ok)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] bits;
    int         nbits;
    bit         exp_done;
    bit         timeout;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [9:0] obs_bits = '0;
  longint     cyc = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference frame: data LSB first, odd parity (total ones odd), stop bit 1.
  function automatic exp_t model(input logic [7:0] d, input int nclk, input bit ack, input bit to);
    exp_t e;
    int ones = 0;
    for (int i = 0; i < 8; i++) begin
      e.bits[i] = d[i];
      ones += int'(d[i]);
    end
    e.bits[8]  = (ones % 2 == 0);
    e.bits[9]  = 1'b1;
    e.nbits    = (nclk < 10) ? nclk : 10;
    e.exp_done = ack && !to && (nclk >= 11);
    e.timeout  = to;
    return e;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic device_run(input int nclk, input bit ack);
    int w = 0;
    obs_bits = '0;
    while (!(clk_pad && !data_pad) && w < INH + 200) begin
      @(negedge clock);
      w++;
    end
    if (w >= INH + 200) begin
      check("rts_wait_expired", w, 0);
      return;
    end
    repeat (HP) @(negedge clock);
    for (int k = 1; k <= nclk; k++) begin
      if (k == 11 && ack) dev_data_low = 1'b1;
      repeat (2) @(negedge clock);
      dev_clk_low = 1'b1;
      repeat (HP) @(negedge clock);
      dev_clk_low = 1'b0;
      @(negedge clock);
      if (k <= 10) obs_bits[k-1] = data_pad;
      repeat (HP) @(negedge clock);
      if (k == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle(input int bound);
    int w = 0;
    while (busy && w < bound) begin
      @(negedge clock);
      w++;
    end
    if (busy) check("idle_wait_expired", busy, 0);
    repeat (5) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d, input int nclk, input bit ack, input bit to);
    exp_q.push_back(model(d, nclk, ack, to));
    pulse_start(d);
    device_run(nclk, ack);
    wait_idle(TO + 500);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a result.
  initial begin
    exp_t   e;
    int     inh_cnt = 0;
    int     rts_cnt = 0;
    logic   prev_err = 1'b0;
    logic   prev_doe = 1'b0;
    longint last_doe_cyc = 0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        inh_cnt = 0;
        rts_cnt = 0;
        prev_err = 1'b0;
        prev_doe = 1'b0;
      end else begin
        if (prev_err) check("error_one_cycle", error, 0);
        if (done || error) begin
          check("done_error_exclusive", done & error, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("done", done, e.exp_done);
            check("error", error, !e.exp_done);
            check("ack_ok", ack_ok, e.exp_done);
            check("busy_at_end", busy, 0);
            check("clk_oe_at_end", ps2_clk_oe, 0);
            check("data_oe_at_end", ps2_data_oe, 0);
            for (int i = 0; i < e.nbits; i++)
              check($sformatf("frame_bit%0d", i), obs_bits[i], e.bits[i]);
            if (e.timeout) check("timeout_latency", cyc - last_doe_cyc, TO);
          end
        end
        if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
        if (ps2_clk_oe && ps2_data_oe) begin
          if (inh_cnt > 0) check("inhibit_len", inh_cnt, INH);
          inh_cnt = 0;
          rts_cnt++;
        end
        if (!ps2_clk_oe) begin
          if (rts_cnt > 0) check("rts_len", rts_cnt, 1);
          rts_cnt = 0;
          inh_cnt = 0;
        end
        if (ps2_data_oe != prev_doe) last_doe_cyc = cyc;
        prev_doe = ps2_data_oe;
        prev_err = error;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int w;
    repeat (3) @(negedge clock);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_ack_ok", ack_ok, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clock);

    send(8'hED, 11, 1'b1, 1'b0);
    send(8'h00, 11, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) send(8'($urandom), 11, 1'b1, 1'b0);
    send(8'hFF, 11, 1'b0, 1'b0);
    send(8'hF4, 4, 1'b1, 1'b1);

    pulse_start(8'h3C);
    device_run(3, 1'b0);
    repeat (20) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("async_rst_clk_oe", ps2_clk_oe, 0);
    check("async_rst_data_oe", ps2_data_oe, 0);
    check("async_rst_busy", busy, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    send(8'hED, 11, 1'b1, 1'b0);

    exp_q.push_back(model(8'h55, 11, 1'b1, 1'b0));
    pulse_start(8'h55);
    fork
      device_run(11, 1'b1);
      begin
        repeat (300) @(negedge clock);
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
      end
    join
    wait_idle(TO + 500);

    d = 8'($urandom);
    exp_q.push_back(model(d, 11, 1'b1, 1'b0));
    pulse_start(d);
    device_run(11, 1'b1);
    w = 0;
    while (!done && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (!done) begin
      check("done_wait_expired", done, 1);
    end else begin
      d = 8'($urandom);
      exp_q.push_back(model(d, 11, 1'b1, 1'b0));
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clock);
      tx_start = 1'b0;
      check("restart_busy", busy, 1);
      check("restart_clk_oe", ps2_clk_oe, 1);
      device_run(11, 1'b1);
    end
    wait_idle(TO + 500);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
